aes_core_arbiter: RTL
=====================

// Module: aes_core_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one AES-128 encrypt core among NUM_REQ
//  requesters (scan-in encryption, scan-out encryption, integrity/MAC path).
//  Accepts a {plaintext,key} job, sequences the core's start/en, waits a fixed
//  core latency, captures the ciphertext and returns it to the granted requester.
// PARAMETERS
//  NUM_REQ   2   number of requesters (legal range 2..4)
//  CORE_LAT  12  clocks from core start being sampled to valid core cyphertext (>=2)
// PORTS
//  clk              in   1            single clock, rising edge
//  reset_n          in   1            asynchronous, active-low reset
//  req_valid        in   NUM_REQ      per-requester job request
//  req_ready        out  NUM_REQ      one-hot job-accept pulse
//  req_plaintext    in   NUM_REQ*128  requester i at [128*i +: 128]
//  req_key          in   NUM_REQ*128  requester i at [128*i +: 128]
//  rsp_valid        out  NUM_REQ      one-hot result valid for the granted requester
//  rsp_ready        in   NUM_REQ      per-requester result accept
//  rsp_data         out  128          ciphertext; shared, qualified by rsp_valid
//  core_start       out  1            start pulse to the encrypt core
//  core_en          out  1            key-expansion enable to the core
//  core_plaintext   out  128          held job plaintext
//  core_key         out  128          held job key; stable for the whole job
//  core_cyphertext  in   128          core result
//  blocks_done      out  16           completed-job count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; data/key/result regs 0; last_grant=NUM_REQ-1.
//  FSM: IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
//  IDLE:  if any req_valid: g = first set bit searching (last_grant+1) mod NUM_REQ
//         upward with wrap; req_ready[g]=1 combinationally this cycle; plaintext/key
//         latched at the edge; grant reg <= g; -> ISSUE. Else stay.
//  ISSUE: core_start=1 for exactly one cycle; core_en=1; cnt <= CORE_LAT-1; -> BUSY.
//  BUSY:  core_en=1; cnt decrements; at cnt==0 rsp_data <= core_cyphertext; -> RESP.
//  RESP:  rsp_valid[grant]=1; rsp_data held; core_en=0. On rsp_ready[grant]:
//         last_grant <= grant; -> IDLE. No new job is accepted before return to IDLE.
//  Latency: accept edge E0; core_start sampled at E1; rsp_valid rises at E1+CORE_LAT.
//  Min back-to-back period per job = CORE_LAT+3 clocks with rsp_ready tied high.
//  core_plaintext/core_key driven from latched regs only, never from req_* buses.
//  req_ready is 0 in every state except IDLE; at most one bit set ever.
//  req_valid dropping before ready: no job, no state change. After accept: ignored.
//  rsp_ready of non-granted requesters ignored; rsp_valid held under backpressure.
//  Simultaneous requests: round-robin; a requester served waits at most NUM_REQ-1 jobs.
//  Async reset mid-job: immediate return to IDLE, outputs 0; job is dropped,
//  no rsp_valid generated; next grant starts at requester 0.
// CONFIGURATION
//  AES_ARB_BLOCK_CNT_EN defined: blocks_done increments by 1 on each RESP
//   handshake, saturates at 16'hFFFF, cleared only by reset.
//  Not defined: counter not built; blocks_done tied to 16'h0000.
// TESTING
//  1 Single job, NUM_REQ=2, req0 pt=00112233445566778899aabbccddeeff key=
//    000102030405060708090a0b0c0d0e0f -> rsp_valid[0] at E1+12, rsp_data=
//    69c4e0d86a7b0430d8cdb78070b4c55a; core_start high exactly 1 cycle.
//  2 req0,req1 asserted together from reset -> grant order 0,1,0,1 over 4 jobs;
//    req_ready never multi-hot; core_key constant throughout each job.
//  3 Backpressure: rsp_ready[0]=0 for 20 cycles -> rsp_valid[0]/rsp_data stable,
//    req_ready stays 0, core_start never pulses; release -> IDLE next cycle.
//  4 reset_n low during BUSY (cnt=5) -> all outputs 0 same cycle, no rsp_valid
//    after release; next job from req0 and req1 grants req0 first.
//  5 req1 pulses valid for one cycle while RESP for req0 -> no job accepted;
//    rsp_ready[1]=1 while rsp_valid[0] -> ignored.
//  6 AES_ARB_BLOCK_CNT_EN: 3 jobs -> blocks_done=3; preload count 16'hFFFE, 3 jobs
//    -> holds 16'hFFFF; macro undefined -> blocks_done=0 always.

Source files
------------

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one AES-128 encrypt core; job accepted in IDLE, result after CORE_LAT+1 clocks.
// Backpressure: rsp_valid/rsp_data held until rsp_ready[grant]; optional job counter under AES_ARB_BLOCK_CNT_EN.
module aes_core_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int CORE_LAT = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_plaintext,
    input  logic [NUM_REQ*128-1:0] req_key,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [127:0]           rsp_data,
    output logic                   core_start,
    output logic                   core_en,
    output logic [127:0]           core_plaintext,
    output logic [127:0]           core_key,
    input  logic [127:0]           core_cyphertext,
    output logic [15:0]            blocks_done
);

    localparam int GW = (NUM_REQ > 2) ? 2 : 1;
    localparam int CW = $clog2(CORE_LAT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, last_grant_q, pick;
    logic            pick_vld;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    sel_pt, sel_key;
    logic            rsp_hs;

    // Lowest requester above last_grant wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i <= int'(last_grant_q)) begin
                pick     = GW'(i);
                pick_vld = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i > int'(last_grant_q)) begin
                pick     = GW'(i);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == pick) begin
                sel_pt  = req_plaintext[128*i +: 128];
                sel_key = req_key[128*i +: 128];
            end
        end
    end

    assign rsp_hs     = (state_q == ST_RESP) && rsp_ready[grant_q];
    assign core_start = (state_q == ST_ISSUE);
    assign core_en    = (state_q == ST_ISSUE) || (state_q == ST_BUSY);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                // Gated by reset_n so the accept pulse is also low while reset is held.
                if (pick_vld && reset_n) begin
                    req_ready[pick] = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY:  if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_hs) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_REQ - 1);
            cnt_q          <= '0;
            core_plaintext <= '0;
            core_key       <= '0;
            rsp_data       <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q        <= pick;
                        core_plaintext <= sel_pt;
                        core_key       <= sel_key;
                    end
                end
                ST_ISSUE: cnt_q <= CW'(CORE_LAT - 1);
                ST_BUSY: begin
                    if (cnt_q == '0) rsp_data <= core_cyphertext;
                    else             cnt_q    <= cnt_q - 1'b1;
                end
                ST_RESP: if (rsp_hs) last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

`ifdef AES_ARB_BLOCK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            blk_cnt_q <= '0;
        else if (rsp_hs && blk_cnt_q != 16'hFFFF) blk_cnt_q <= blk_cnt_q + 16'd1;
    end

    assign blocks_done = blk_cnt_q;
`else
    assign blocks_done = 16'h0000;
`endif

endmodule
